// File: rtl/spart_bus_sequencer.sv
// Bus-side sequencer for the SPART processor interface: programs the baud
// divisor from br_cfg, then shuttles bytes between host FIFOs and the SPART.

module spart_seq_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    // a pop frees the slot, so push on full succeeds only alongside a real pop
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

module spart_bus_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter logic [15:0] DIV0  = 16'h0516,
  parameter logic [15:0] DIV1  = 16'h028B,
  parameter logic [15:0] DIV2  = 16'h0145,
  parameter logic [15:0] DIV3  = 16'h00A2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  input  logic [7:0] tx_data,
  input  logic       tx_push,
  output logic       tx_full,
  output logic [7:0] rx_data,
  input  logic       rx_pop,
  output logic       rx_empty,
  output logic       cfg_done
);
  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    TX_WR,
    TX_HOLD,
    RX_RD,
    RX_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [1:0]  cfg_sel_q, cfg_sel_d;
  logic        cfg_done_q, cfg_done_d;
  logic [15:0] div_sel;
  logic        bus_oe;
  logic [7:0]  bus_out;
  logic        tx_pop, rx_push;
  logic        tx_empty, rx_full;
  logic [7:0]  tx_head;

  always_comb begin
    case (cfg_sel_q)
      2'b00:   div_sel = DIV0;
      2'b01:   div_sel = DIV1;
      2'b10:   div_sel = DIV2;
      default: div_sel = DIV3;
    endcase
  end

  // run_q is low for the first edge after reset so CFG_LO drives the bus
  // only once rst has been released, not while it is held.
  always_comb begin
    state_d    = state_q;
    cfg_sel_d  = cfg_sel_q;
    cfg_done_d = cfg_done_q;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = 2'b00;
    bus_oe     = 1'b0;
    bus_out    = '0;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    if (run_q) begin
      case (state_q)
        CFG_LO: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = 2'b10;
          bus_oe  = 1'b1;
          bus_out = div_sel[7:0];
          state_d = CFG_HI;
        end
        CFG_HI: begin
          iocs       = 1'b1;
          iorw       = 1'b0;
          ioaddr     = 2'b11;
          bus_oe     = 1'b1;
          bus_out    = div_sel[15:8];
          cfg_done_d = 1'b1;
          state_d    = IDLE;
        end
        IDLE: begin
          if (br_cfg != cfg_sel_q) begin
            cfg_sel_d  = br_cfg;
            cfg_done_d = 1'b0;
            state_d    = CFG_LO;
          end else if (rda && !rx_full) begin
            state_d = RX_RD;
          end else if (tbr && !tx_empty) begin
            state_d = TX_WR;
          end
        end
        RX_RD: begin
          iocs    = 1'b1;
          iorw    = 1'b1;
          rx_push = 1'b1;
          state_d = RX_HOLD;
        end
        TX_WR: begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          bus_oe  = 1'b1;
          bus_out = tx_head;
          tx_pop  = 1'b1;
          state_d = TX_HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      run_q      <= 1'b0;
      cfg_sel_q  <= br_cfg;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      cfg_sel_q  <= cfg_sel_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  assign databus  = bus_oe ? bus_out : 'z;
  assign cfg_done = cfg_done_q;

  spart_seq_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (tx_data),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spart_seq_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (databus),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );
endmodule

// File: tb/tb_spart_bus_sequencer.sv
// Bench for spart_bus_sequencer: a bus monitor checks every SPART access
// against a queue of expected accesses; scenario tasks check flags and timing.

module tb_spart_bus_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b10;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda = 1'b0, tbr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_push = 1'b0;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_pop = 1'b0;
  logic       rx_empty;
  logic       cfg_done;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] rx_model_q[$];
  acc_t       e;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_buf_cyc = -1;
  int         last_rd_cyc = 0;
  int         last_wr_cyc = 0;
  bit         rda_auto = 1'b0;
  bit         adv_rx = 1'b0;
  logic [7:0] spart_rx = 8'h00;

  spart_bus_sequencer #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .tx_data  (tx_data),
    .tx_push  (tx_push),
    .tx_full  (tx_full),
    .rx_data  (rx_data),
    .rx_pop   (rx_pop),
    .rx_empty (rx_empty),
    .cfg_done (cfg_done)
  );

  // SPART side: returns spart_rx on buffer reads
  assign databus = (iocs && iorw) ? spart_rx : 8'hzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (adv_rx) begin
      spart_rx = spart_rx + 8'd1;
      adv_rx   = 1'b0;
    end
    if (iocs === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL access_unexpected: got rw=%b addr=%b data=%h, required no access (cycle %0d)",
                 iorw, ioaddr, databus, cyc);
      end else begin
        e = exp_q.pop_front();
        if (iorw !== e.rw || ioaddr !== e.addr || (!e.rw && databus !== e.data)) begin
          miscompares++;
          $display("FAIL access: got rw=%b addr=%b data=%h, required rw=%b addr=%b data=%h (cycle %0d)",
                   iorw, ioaddr, databus, e.rw, e.addr, e.data, cyc);
        end
      end
      if (iorw === 1'b1) begin
        rx_model_q.push_back(spart_rx);
        adv_rx      = 1'b1;
        last_rd_cyc = cyc;
        if (rda_auto) rda = 1'b0;
      end else if (ioaddr === 2'b00) begin
        last_wr_cyc = cyc;
      end
      if (ioaddr === 2'b00) begin
        if (last_buf_cyc >= 0) begin
          vectors++;
          if (cyc - last_buf_cyc < 3) begin
            miscompares++;
            $display("FAIL access_spacing: got %0d cycles, required >= 3", cyc - last_buf_cyc);
          end
        end
        last_buf_cyc = cyc;
      end
    end
  end

  function automatic logic [15:0] div_of(input logic [1:0] s);
    case (s)
      2'b00:   return 16'h0516;
      2'b01:   return 16'h028B;
      2'b10:   return 16'h0145;
      default: return 16'h00A2;
    endcase
  endfunction

  task automatic push_cfg_exp(input logic [1:0] s);
    logic [15:0] d;
    d = div_of(s);
    exp_q.push_back(acc_t'{1'b0, 2'b10, d[7:0]});
    exp_q.push_back(acc_t'{1'b0, 2'b11, d[15:8]});
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    rst = 1'b1;
    br_cfg = 2'b10;
    repeat (3) @(negedge clk);
    vectors++; if (iocs !== 1'b0) begin miscompares++; $display("FAIL reset_iocs: got %b, required 0", iocs); end
    vectors++; if (iorw !== 1'b1) begin miscompares++; $display("FAIL reset_iorw: got %b, required 1", iorw); end
    vectors++; if (ioaddr !== 2'b00) begin miscompares++; $display("FAIL reset_ioaddr: got %b, required 00", ioaddr); end
    vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL reset_tx_full: got %b, required 0", tx_full); end
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL reset_rx_empty: got %b, required 1", rx_empty); end
    vectors++; if (cfg_done !== 1'b0) begin miscompares++; $display("FAIL reset_cfg_done: got %b, required 0", cfg_done); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    last_buf_cyc = -1;
    push_cfg_exp(2'b10);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (cfg_done !== 1'b0) begin miscompares++; $display("FAIL cfg_done_c1: got %b, required 0", cfg_done); end
    @(negedge clk);
    vectors++; if (cfg_done !== 1'b0) begin miscompares++; $display("FAIL cfg_done_c2: got %b, required 0", cfg_done); end
    @(negedge clk);
    vectors++; if (cfg_done !== 1'b1) begin miscompares++; $display("FAIL cfg_done_c3: got %b, required 1", cfg_done); end
    drain(2, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL reset_cfg_writes: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_tx;
    bit ok;
    bit saw_full;
    tbr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = 8'h61 + 8'(i);
      tx_push = 1'b1;
      exp_q.push_back(acc_t'{1'b0, 2'b00, 8'h61 + 8'(i)});
      @(negedge clk);
      saw_full = saw_full | tx_full;
    end
    tx_push = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      saw_full = saw_full | tx_full;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL tx_three_writes: got %0d pending, required 0", exp_q.size()); end
    vectors++; if (saw_full !== 1'b0) begin miscompares++; $display("FAIL tx_full_three: got %b, required 0", saw_full); end
    repeat (4) @(negedge clk);
    tbr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_data = 8'hB0 + 8'(i);
      tx_push = 1'b1;
      if (i < 4) exp_q.push_back(acc_t'{1'b0, 2'b00, 8'hB0 + 8'(i)});
      @(negedge clk);
      if (i == 3) begin
        vectors++; if (tx_full !== 1'b1) begin miscompares++; $display("FAIL tx_full_after_4: got %b, required 1", tx_full); end
      end
    end
    tx_push = 1'b0;
    tbr = 1'b1;
    drain(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL tx_four_writes: got %0d pending, required 0", exp_q.size()); end
    repeat (10) @(negedge clk);
    vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL tx_full_drained: got %b, required 0", tx_full); end
    tbr = 1'b0;
  endtask

  task automatic test_loopback;
    bit ok;
    tbr = 1'b1;
    exp_q.push_back(acc_t'{1'b0, 2'b00, 8'h61});
    push_tx(8'h61);
    drain(20, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL loop_tx: got %0d pending, required 0", exp_q.size()); end
    tbr = 1'b0;
    repeat (4) @(negedge clk);
    spart_rx = 8'h61;
    rda_auto = 1'b1;
    exp_q.push_back(acc_t'{1'b1, 2'b00, 8'h00});
    rda = 1'b1;
    drain(20, ok);
    @(negedge clk);
    vectors++; if (!ok) begin miscompares++; $display("FAIL loop_rx_read: got %0d pending, required 0", exp_q.size()); end
    vectors++; if (rx_empty !== 1'b0) begin miscompares++; $display("FAIL loop_rx_empty: got %b, required 0", rx_empty); end
    vectors++; if (rx_data !== 8'h61) begin miscompares++; $display("FAIL loop_rx_data: got %h, required 61", rx_data); end
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    void'(rx_model_q.pop_front());
    vectors++; if (rx_empty !== 1'b1) begin miscompares++; $display("FAIL loop_rx_pop: got %b, required 1", rx_empty); end
    rda_auto = 1'b0;
  endtask

  task automatic test_priority;
    bit ok;
    logic [7:0] want;
    tbr = 1'b0;
    push_tx(8'h70);
    @(negedge clk);
    spart_rx = 8'h33;
    rda_auto = 1'b1;
    exp_q.push_back(acc_t'{1'b1, 2'b00, 8'h00});
    exp_q.push_back(acc_t'{1'b0, 2'b00, 8'h70});
    rda = 1'b1;
    tbr = 1'b1;
    drain(30, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL prio_accesses: got %0d pending, required 0", exp_q.size()); end
    vectors++; if (last_wr_cyc - last_rd_cyc !== 3) begin miscompares++; $display("FAIL prio_gap: got %0d cycles, required 3", last_wr_cyc - last_rd_cyc); end
    tbr = 1'b0;
    rda_auto = 1'b0;
    @(negedge clk);
    want = rx_model_q.pop_front();
    vectors++; if (rx_data !== want) begin miscompares++; $display("FAIL prio_rx_data: got %h, required %h", rx_data, want); end
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic test_cfg_change;
    bit ok;
    bit found;
    push_cfg_exp(2'b00);
    br_cfg = 2'b00;
    drain(20, ok);
    repeat (2) @(negedge clk);
    vectors++; if (!ok || cfg_done !== 1'b1) begin miscompares++; $display("FAIL cfg00: got done=%b pending=%0d, required done=1 pending=0", cfg_done, exp_q.size()); end
    tbr = 1'b1;
    exp_q.push_back(acc_t'{1'b0, 2'b00, 8'h5A});
    push_tx(8'h5A);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b00) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL cfg_tx_seen: got no TX write, required one within 20 cycles"); end
    push_cfg_exp(2'b11);
    @(negedge clk);
    br_cfg = 2'b11;
    vectors++; if (cfg_done !== 1'b1) begin miscompares++; $display("FAIL cfg_hold_done: got %b, required 1", cfg_done); end
    @(negedge clk);
    vectors++; if (iocs !== 1'b0 || cfg_done !== 1'b1) begin miscompares++; $display("FAIL cfg_idle: got iocs=%b done=%b, required iocs=0 done=1", iocs, cfg_done); end
    @(negedge clk);
    vectors++; if (cfg_done !== 1'b0) begin miscompares++; $display("FAIL cfg_lo_done: got %b, required 0", cfg_done); end
    @(negedge clk);
    vectors++; if (cfg_done !== 1'b0) begin miscompares++; $display("FAIL cfg_hi_done: got %b, required 0", cfg_done); end
    @(negedge clk);
    vectors++; if (cfg_done !== 1'b1) begin miscompares++; $display("FAIL cfg_redone: got %b, required 1", cfg_done); end
    tbr = 1'b0;
    drain(4, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL cfg11_writes: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_rx_full_and_reset;
    bit ok;
    bit found;
    logic [7:0] want;
    rda_auto = 1'b0;
    spart_rx = 8'h80;
    for (int i = 0; i < 4; i++) exp_q.push_back(acc_t'{1'b1, 2'b00, 8'h00});
    rda = 1'b1;
    drain(60, ok);
    repeat (12) @(negedge clk);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rxfull_reads: got %0d pending, required 0", exp_q.size()); end
    want = rx_model_q[0];
    vectors++; if (rx_empty !== 1'b0 || rx_data !== want) begin miscompares++; $display("FAIL rxfull_head: got empty=%b data=%h, required empty=0 data=%h", rx_empty, rx_data, want); end
    exp_q.push_back(acc_t'{1'b1, 2'b00, 8'h00});
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    void'(rx_model_q.pop_front());
    drain(20, ok);
    repeat (12) @(negedge clk);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rxfull_refill: got %0d pending, required 0", exp_q.size()); end
    want = rx_model_q[0];
    vectors++; if (rx_data !== want) begin miscompares++; $display("FAIL rxfull_next_head: got %h, required %h", rx_data, want); end
    rda = 1'b0;
    tbr = 1'b1;
    exp_q.push_back(acc_t'{1'b0, 2'b00, 8'h99});
    push_tx(8'h99);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (iocs === 1'b1 && iorw === 1'b0 && ioaddr === 2'b00) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL rst_tx_seen: got no TX write, required one within 20 cycles"); end
    rst = 1'b1;
    tbr = 1'b0;
    @(negedge clk);
    vectors++; if (iocs !== 1'b0 || iorw !== 1'b1) begin miscompares++; $display("FAIL rst_mid_bus: got iocs=%b iorw=%b, required iocs=0 iorw=1", iocs, iorw); end
    vectors++; if (cfg_done !== 1'b0 || rx_empty !== 1'b1 || tx_full !== 1'b0) begin miscompares++; $display("FAIL rst_mid_flags: got done=%b rx_empty=%b tx_full=%b, required 0 1 0", cfg_done, rx_empty, tx_full); end
    exp_q.delete();
    rx_model_q.delete();
    last_buf_cyc = -1;
    adv_rx = 1'b0;
    push_cfg_exp(2'b11);
    @(negedge clk);
    rst = 1'b0;
    drain(10, ok);
    repeat (3) @(negedge clk);
    vectors++; if (!ok || cfg_done !== 1'b1) begin miscompares++; $display("FAIL rst_reconfig: got done=%b pending=%0d, required done=1 pending=0", cfg_done, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_loopback();
    test_priority();
    test_cfg_change();
    test_rx_full_and_reset();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
